// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC controller and its return stack.
package fetch_pkg;

  localparam int unsigned REG_WIDTH = 32;

  typedef logic [REG_WIDTH-1:0] addr_t;

  localparam addr_t RESET_PC_DEFAULT = 32'h8000_0000;
  localparam addr_t PC_STEP          = 32'd4;
  localparam addr_t CALL_RET_OFFSET  = 32'd8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SLOT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop when empty is ignored by the caller gating. Power-of-two DEPTH.
module return_stack
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  addr_t                    push_data_i,
  output addr_t                    top_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  addr_t             mem_q [DEPTH];
  addr_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  top_idx;

  // ptr_q is the next write slot; the top lives one below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i && pop_i && (count_q != '0)) begin
      mem_d[top_idx] = push_data_i;
    end else if (push_i) begin
      mem_d[ptr_q] = push_data_i;
      ptr_d        = ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop_i && (count_q != '0)) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch PC sequencer with one branch delay slot and backend redirect.
// Optional return stack built when FETCH_RAS_EN is defined.
module fetch_pc_controller
  import fetch_pkg::*;
#(
  parameter addr_t       RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         inst_valid,
  input  logic                         pred_taken,
  input  logic                         pred_is_branch,
  input  logic                         pred_is_call,
  input  logic                         pred_is_return,
  input  addr_t                        pred_addr,
  input  logic                         redirect,
  input  addr_t                        redirect_addr,
  output addr_t                        pc_o,
  output logic                         in_slot_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  addr_t             pc_q, pc_d;
  addr_t             pending_q, pending_d;

  logic              accept_c;
  logic              eff_taken_c;
  addr_t             eff_target_c;
  addr_t             ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_nonempty;
  logic              branch_unused;

  // Branch kind is implied by pred_taken; the flag is informational only.
  assign branch_unused = pred_is_branch;

  assign accept_c = inst_valid & ~stall & ~redirect;

`ifdef FETCH_RAS_EN
  logic  ras_push, ras_pop;
  addr_t ras_push_data;

  assign ras_push      = accept_c & (state_q == ST_RUN) & pred_is_call;
  assign ras_pop       = accept_c & (state_q == ST_RUN) & pred_is_return & ras_nonempty;
  assign ras_push_data = pc_q + CALL_RET_OFFSET;

  return_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_return_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (ras_push_data),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );
`else
  logic call_unused;

  assign call_unused = pred_is_call;
  assign ras_top     = '0;
  assign ras_count   = '0;
`endif

  assign ras_nonempty = (ras_count != '0);

  // Returns follow the stack when it has an entry, otherwise fall through.
  always_comb begin
    eff_taken_c  = pred_taken;
    eff_target_c = pred_addr;
    if (pred_is_return) begin
      eff_taken_c  = ras_nonempty;
      eff_target_c = ras_top;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    if (redirect) begin
      state_d   = ST_RUN;
      pc_d      = redirect_addr;
      pending_d = '0;
    end else if (accept_c) begin
      case (state_q)
        ST_RUN: begin
          pc_d = pc_q + PC_STEP;
          if (eff_taken_c) begin
            pending_d = eff_target_c;
            state_d   = ST_SLOT;
          end
        end
        ST_SLOT: begin
          pc_d      = pending_q;
          pending_d = '0;
          state_d   = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

  assign pc_o        = pc_q;
  assign in_slot_o   = (state_q == ST_SLOT);
  assign ras_count_o = ras_count;

endmodule
